// File: rtl/keypad_pkg.sv
// keypad_pkg: FSM encoding, matrix geometry and lowest-low-column helper for keypad_scan
package keypad_pkg;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int CODE_W = 4;
  localparam logic [ROWS-1:0] ROW_RST = 4'b1110;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;
  function automatic logic [$clog2(COLS)-1:0] low_col(input logic [COLS-1:0] c);
    low_col = '0;
    for (int i = COLS - 1; i >= 0; i--) if (!c[i]) low_col = i[$clog2(COLS)-1:0];
  endfunction
endpackage

// File: rtl/col_sync.sv
// col_sync: two-flop synchronizer for the asynchronous, active-low column inputs
module col_sync #(
  parameter int W = 4,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  assign q = sync_q;
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounced press and release detection.
// Defining KEYPAD_SCAN_REPEAT_EN adds auto-repeat pulses while a key stays held.
module keypad_scan import keypad_pkg::*; #(
  parameter int SCAN_DIV      = 100000,
  parameter int DEBOUNCE_CNT  = 20,
  parameter int REPEAT_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ROWS-1:0]   row_out,
  input  logic [COLS-1:0]   col_in,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_held
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int VW = $clog2(SCAN_DIV);
  localparam int MW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [VW-1:0] DIV_MAX = VW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] DB_MAX = MW'(DEBOUNCE_CNT);
  if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("keypad_scan: parameter out of range");
  end
  state_t state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [VW-1:0] div_q, div_d;
  logic [MW-1:0] match_q, match_d, rel_q, rel_d;
  logic [CW-1:0] cap_q, cap_d, lc;
  logic [ROWS-1:0] row_out_q, row_out_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic key_valid_q, key_valid_d, key_held_q, key_held_d;
  logic [COLS-1:0] col_s;
  logic sample, any_low, accept;
`ifdef KEYPAD_SCAN_REPEAT_EN
  localparam int PW = $clog2(REPEAT_CYCLES);
  localparam logic [PW-1:0] REP_MAX = PW'(REPEAT_CYCLES - 1);
  logic [PW-1:0] rep_q, rep_d;
`endif
  col_sync #(.W(COLS), .RST_VAL('1)) u_sync (.clk(clk), .rst(rst), .d(col_in), .q(col_s));
  assign sample = div_q == DIV_MAX;
  assign any_low = ~&col_s;
  assign lc = low_col(col_s);
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    div_d = sample ? '0 : div_q + 1'b1;
    match_d = match_q;
    rel_d = rel_q;
    cap_d = cap_q;
    key_valid_d = 1'b0;
    key_code_d = key_code_q;
    key_held_d = key_held_q;
    if (sample)
      case (state_q)
        SCAN:
          if (any_low) begin
            cap_d = lc;
            match_d = MW'(1);
            state_d = DEBOUNCE;
          end else row_d = row_q + 1'b1;
        DEBOUNCE:
          if (any_low && lc == cap_q) match_d = match_q + 1'b1;
          else begin
            state_d = SCAN;
            row_d = row_q + 1'b1;
          end
        HOLD: begin
          rel_d = col_s[cap_q] ? rel_q + 1'b1 : '0;
          if (rel_d == DB_MAX) begin
            state_d = SCAN;
            row_d = row_q + 1'b1;
            rel_d = '0;
            key_held_d = 1'b0;
          end
        end
        default: state_d = SCAN;
      endcase
    // a capture with DEBOUNCE_CNT=1 lands here directly from SCAN
    accept = sample && state_d == DEBOUNCE && match_d == DB_MAX;
    if (accept) begin
      state_d = HOLD;
      match_d = '0;
      rel_d = '0;
      key_valid_d = 1'b1;
      key_code_d = {row_q, cap_d};
      key_held_d = 1'b1;
    end
`ifdef KEYPAD_SCAN_REPEAT_EN
    rep_d = (state_q == HOLD && state_d == HOLD) ? (rep_q == REP_MAX ? '0 : rep_q + 1'b1) : '0;
    if (state_q == HOLD && state_d == HOLD && rep_q == REP_MAX && rel_q == '0) key_valid_d = 1'b1;
`endif
    row_out_d = ~(ROWS'(1) << row_d);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= SCAN;
      row_q <= '0;
      div_q <= '0;
      match_q <= '0;
      rel_q <= '0;
      cap_q <= '0;
      row_out_q <= ROW_RST;
      key_valid_q <= 1'b0;
      key_code_q <= '0;
      key_held_q <= 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
      rep_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      div_q <= div_d;
      match_q <= match_d;
      rel_q <= rel_d;
      cap_q <= cap_d;
      row_out_q <= row_out_d;
      key_valid_q <= key_valid_d;
      key_code_q <= key_code_d;
      key_held_q <= key_held_d;
`ifdef KEYPAD_SCAN_REPEAT_EN
      rep_q <= rep_d;
`endif
    end
  assign row_out = row_out_q;
  assign key_valid = key_valid_q;
  assign key_code = key_code_q;
  assign key_held = key_held_q;
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: keypad_scan bench with a physical keypad model and a sample-level reference model
module tb_keypad_scan;
  localparam int SD = 4;
  localparam int DB = 3;
  localparam int RC = 64;
  typedef struct {
    int         row;
    logic [3:0] cols;
    int         dur;
    logic [3:0] code;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] row_out, col_in, key_code;
  logic key_valid, key_held;
  logic [15:0] pressed = '0;
  int errs = 0, checks = 0;
  int k, m_st, m_row, m_cnt, m_cap, m_rel, m_ks, lc_m;
  bit m_smp, was_hold, rel0;
  logic e_valid, e_held;
  logic [3:0] e_code, e_row;
  int npulse = 0, cyc = 0, p0;
  logic [3:0] last_code = '0;
  logic prev_v = 1'b0;
  int ptimes[$];
  logic [3:0] pcodes[$];
  vec_t tbl[7];
  always #5 clk = ~clk;
  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB), .REPEAT_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .row_out(row_out), .col_in(col_in),
    .key_valid(key_valid), .key_code(key_code), .key_held(key_held));
  // Physical matrix: a pressed key pulls its column low while its row is driven low
  always_comb begin
    col_in = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!row_out[r] && pressed[r*4+c]) col_in[c] = 1'b0;
  end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int low_pressed(input int r);
    for (int c = 0; c < 4; c++) if (pressed[r*4+c]) return c;
    return -1;
  endfunction
  // Reference: decisions taken once per dwell from the pressed-key set (0=scan,1=debounce,2=hold)
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k = 0; m_st = 0; m_row = 0; m_cnt = 0; m_cap = 0; m_rel = 0; m_ks = 0;
      m_smp = 0; e_valid = 0; e_code = 0; e_held = 0;
    end else begin
      was_hold = m_st == 2;
      rel0 = m_rel == 0;
      e_valid = 0;
      m_smp = (k % SD) == SD - 1;
      if (m_smp) begin
        lc_m = low_pressed(m_row);
        if (m_st == 0) begin
          if (lc_m >= 0) begin m_cap = lc_m; m_cnt = 1; m_st = 1; end
          else m_row = (m_row + 1) % 4;
        end else if (m_st == 1) begin
          if (lc_m == m_cap) m_cnt++;
          else begin m_st = 0; m_row = (m_row + 1) % 4; end
        end else begin
          if (pressed[m_row*4+m_cap]) m_rel = 0; else m_rel++;
          if (m_rel == DB) begin m_st = 0; m_rel = 0; e_held = 0; m_row = (m_row + 1) % 4; end
        end
        if (m_st == 1 && m_cnt == DB) begin
          m_st = 2; e_valid = 1; e_code = 4'(m_row * 4 + m_cap); e_held = 1; m_ks = k; m_rel = 0;
        end
      end
`ifdef KEYPAD_SCAN_REPEAT_EN
      if (was_hold && m_st == 2 && rel0 && (k - m_ks) % RC == 0) e_valid = 1;
`endif
      k++;
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      e_row = ~(4'b0001 << m_row);
      chk("key_valid", key_valid, e_valid);
      chk("key_code", key_code, e_code);
      chk("key_held", key_held, e_held);
      chk("row_out", row_out, e_row);
      if (key_valid) begin
        chk("valid_consecutive", prev_v, 0);
        npulse++;
        last_code = key_code;
        ptimes.push_back(cyc);
        pcodes.push_back(key_code);
      end
    end
    prev_v = rst ? 1'b0 : key_valid;
    cyc++;
  end
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic align_row(input int r);
    int t = 0;
    do begin @(negedge clk); t++; end while (!(m_smp && m_row == r) && t < 200);
    chk("align_row", int'(m_smp && m_row == r), 1);
  endtask
  initial begin
    tbl = '{'{1, 4'b0100, 40, 4'h6}, '{2, 4'b1010, 40, 4'h9}, '{3, 4'b1000, 40, 4'hF},
            '{0, 4'b0001, 40, 4'h0}, '{2, 4'b0001, 40, 4'h8}, '{0, 4'b1100, 40, 4'h2},
            '{3, 4'b0010, 40, 4'hD}};
    cycles(3);
    chk("rst_row_out", row_out, 4'b1110);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_code", key_code, 0);
    chk("rst_key_held", key_held, 0);
    rst = 1'b0;
    cycles(20);
    foreach (tbl[i]) begin
      align_row(0);
      p0 = npulse;
      pressed[tbl[i].row*4 +: 4] = tbl[i].cols;
      cycles(tbl[i].dur);
      chk("tbl_held", key_held, 1);
      pressed = '0;
      cycles(40);
      chk("tbl_pulses", npulse - p0, 1);
      chk("tbl_code", last_code, tbl[i].code);
      chk("tbl_released", key_held, 0);
    end
    // single-sample glitch on row0/col0
    align_row(0);
    p0 = npulse;
    pressed[0] = 1'b1;
    cycles(4);
    pressed[0] = 1'b0;
    cycles(4);
    chk("glitch_row", row_out, 4'b1101);
    chk("glitch_pulses", npulse - p0, 0);
    chk("glitch_held", key_held, 0);
    // bounce on row1/col2: low, high, then steady low
    align_row(1);
    p0 = npulse;
    pressed[6] = 1'b1;
    cycles(4);
    pressed[6] = 1'b0;
    cycles(4);
    pressed[6] = 1'b1;
    chk("bounce_early", npulse - p0, 0);
    cycles(40);
    chk("bounce_pulses", npulse - p0, 1);
    chk("bounce_code", last_code, 4'h6);
    pressed = '0;
    cycles(40);
    chk("bounce_after_release", npulse - p0, 1);
    chk("bounce_held", key_held, 0);
    // row3/col3 held for 200 cycles
    align_row(0);
    ptimes.delete();
    pcodes.delete();
    pressed[15] = 1'b1;
    cycles(200);
    pressed = '0;
    cycles(40);
    foreach (pcodes[i]) chk("rpt_code", pcodes[i], 4'hF);
`ifdef KEYPAD_SCAN_REPEAT_EN
    chk("rpt_count_ge3", int'(ptimes.size() >= 3), 1);
    for (int i = 1; i < ptimes.size(); i++) chk("rpt_gap", ptimes[i] - ptimes[i-1], RC);
`else
    chk("rpt_count", ptimes.size(), 1);
`endif
    // reset while holding a row2 key
    align_row(2);
    pressed[8] = 1'b1;
    cycles(30);
    chk("pre_rst_held", key_held, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_row_out", row_out, 4'b1110);
    chk("async_rst_key_valid", key_valid, 0);
    chk("async_rst_key_code", key_code, 0);
    chk("async_rst_key_held", key_held, 0);
    cycles(2);
    rst = 1'b0;
    p0 = npulse;
    cycles(40);
    chk("post_rst_pulses", npulse - p0, 1);
    chk("post_rst_code", last_code, 4'h8);
    pressed = '0;
    cycles(40);
    for (int n = 0; n < 40; n++) begin
      align_row(n % 4);
      pressed[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, 15)] = 1'b1;
      cycles(SD * $urandom_range(1, 20));
      pressed = '0;
      cycles(SD * $urandom_range(1, 8));
    end
    cycles(50);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk cycles each row is driven (minimum 2).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 20, consecutive consistent samples needed to accept a press or a release (minimum 1).
REQ-003 SHALL have parameter REPEAT_CYCLES, default 50000000, auto-repeat period in clk cycles (used only with the macro in REQ-020).
REQ-004 SHALL have port clk, input, 1, single system clock; all flops rising-edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port row_out, output, 4, row drive, active-low, exactly one bit low at any time.
REQ-007 SHALL have port col_in, input, 4, column sense, active-low (pulled up externally), asynchronous to clk.
REQ-008 SHALL have port key_valid, output, 1, one-cycle pulse per accepted key event.
REQ-009 SHALL have port key_code, output, 4, code = row*4 + col of the last accepted key.
REQ-010 SHALL have port key_held, output, 1, high while an accepted key remains pressed.

Function
REQ-011 SHALL pass col_in through a 2-flop synchronizer whose reset value is 4'hF; all decisions SHALL use the synchronized value only.
- Dwell counter runs 0..SCAN_DIV-1 per row. Sample point = cycle where the counter equals SCAN_DIV-1.
REQ-012 SHALL implement the FSM states SCAN, DEBOUNCE and HOLD.
- SCAN: the row index advances 0->1->2->3->0 at each sample point; row_out = ~(1<<row).
- If any synchronized column is low at a sample point: capture code = row*4 + lowest low column index; row locks; match count = 1; go to DEBOUNCE. If DEBOUNCE_CNT=1, go straight to acceptance.
REQ-013 DEBOUNCE SHALL sample at each sample point on the locked row.
- Same lowest-low column: match count increments.
- Different column or no column low: return to SCAN; the row advances to the next row; no pulse.
- When the match count reaches DEBOUNCE_CNT: key_valid is high for exactly the following cycle, key_code updates in that same cycle, state goes to HOLD.
REQ-014 HOLD SHALL set key_held=1 and keep the row locked.
- At each sample point where the captured column is high, the release count increments. If the captured column is low again, the release count clears.
- When the release count reaches DEBOUNCE_CNT: key_held=0 in the next cycle; go to SCAN on the next row.
REQ-015 Other keys pressed while in DEBOUNCE or HOLD SHALL be ignored unless they change the lowest-low column on the locked row; in DEBOUNCE that change counts as a mismatch.
REQ-016 key_code SHALL hold its value between accepted events; key_valid SHALL never be high on two consecutive cycles.

Reset
REQ-017 Asserting rst SHALL immediately force: row_out=4'b1110, key_valid=0, key_code=4'h0, key_held=0, state SCAN, row 0, all counters 0, synchronizer 4'hF.
REQ-018 Reset mid-debounce or mid-hold SHALL discard the pending event; no pulse SHALL occur after rst deasserts until a fresh full debounce completes.
REQ-019 The first dwell after rst deasserts SHALL last a full SCAN_DIV cycles on row 0.

Configuration
REQ-020 Macro KEYPAD_SCAN_REPEAT_EN.
- When defined: in HOLD, a counter starts at the accepting pulse. Every REPEAT_CYCLES cycles while the release count is 0, key_valid pulses again with the unchanged key_code. Counter clears on leaving HOLD.
- When undefined: exactly one key_valid pulse per press, and no repeat logic is synthesized.

Structure
REQ-021 Package keypad_pkg SHALL hold the FSM state encoding, constants ROWS=4, COLS=4, CODE_W=4, and the row-drive reset value 4'b1110.
REQ-022 The synchronizer SHALL be a sub-module named col_sync (parameterized width, reset value 4'hF); counters and FSM stay in keypad_scan.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_CYCLES=64)
REQ-023 Assert rst mid-dwell on row 2 -> same-cycle row_out=4'b1110, key_valid=0, key_code=0, key_held=0.
REQ-024 Hold col2 low while row1 is driven (steady) -> exactly one key_valid pulse with key_code=4'h6, key_held=1. Release -> key_held=0 after 3 high samples; no further pulse.
REQ-025 Bounce on row1/col2: low, high, low, low, low at successive sample points -> no pulse on the first low; single pulse with code 6 only after 3 consecutive lows.
REQ-026 Row2 with col1 and col3 both low -> key_code=4'h9 (lowest column wins).
REQ-027 One-sample glitch on row0/col0 -> no pulse, key_held stays 0, and the next dwell drives row_out=4'b1101.
REQ-028 Row3/col3 held for 200 cycles -> with KEYPAD_SCAN_REPEAT_EN: initial pulse code 4'hF, then further pulses spaced 64 cycles apart; without the macro: exactly one pulse.
